// File: rtl/rr_grant_arbiter_8.sv
// Eight-requester round-robin arbiter: one registered owner at a time, held until
// the owner drops its request or the optional hold timeout forces a release.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; next edge grants the first requester from ptr
// S_GRANT | gnt_idx owns the resource; hold_cnt counts cycles held
module rr_grant_arbiter_8 #(
    parameter  int TIMEOUT = 16,
    localparam int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout_pulse
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic             TO_EN     = (TIMEOUT != 0);

    logic [0:0]       state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [7:0]       gnt_q, gnt_d;
    logic             timeout_pulse_q, timeout_pulse_d;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             owner_req;
    logic             hold_last;
    logic             release_now;
    logic             forced;

    // Search starts at ptr and wraps modulo 8, so the 3-bit add does the wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int off = 0; off < 8; off++) begin
            cand = ptr_q + 3'(off);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_req   = req[gnt_idx_q];
        hold_last   = TO_EN && (hold_cnt_q == HOLD_LAST);
        release_now = !owner_req || hold_last;
        forced      = owner_req && hold_last;
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        hold_cnt_d      = hold_cnt_q;
        gnt_idx_d       = gnt_idx_q;
        gnt_valid_d     = gnt_valid_q;
        timeout_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    gnt_valid_d     = 1'b0;
                    ptr_d           = gnt_idx_q + 3'd1;
                    hold_cnt_d      = '0;
                    state_d         = S_IDLE;
                    timeout_pulse_d = forced;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    // Grant vector is registered alongside the index so both change on the same edge.
    always_comb begin
        gnt_d = 8'h00;
        if (gnt_valid_d) begin
            gnt_d[gnt_idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            ptr_q           <= 3'd0;
            hold_cnt_q      <= '0;
            gnt_idx_q       <= 3'd0;
            gnt_valid_q     <= 1'b0;
            gnt_q           <= 8'h00;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            hold_cnt_q      <= hold_cnt_d;
            gnt_idx_q       <= gnt_idx_d;
            gnt_valid_q     <= gnt_valid_d;
            gnt_q           <= gnt_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign gnt           = gnt_q;
    assign gnt_idx       = gnt_idx_q;
    assign gnt_valid     = gnt_valid_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_rr_grant_arbiter_8.sv
// Bench for rr_grant_arbiter_8: three instances (TIMEOUT 4, 0 and default 16)
// compared every cycle against an owner/pointer reference model.
module tb_rr_grant_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_v   [3];
    logic [7:0] gnt_o   [3];
    logic [2:0] idx_o   [3];
    logic       val_o   [3];
    logic       tp_o    [3];

    int checks   = 0;
    int failures = 0;

    // Reference model: owner=-1 means nobody holds the resource.
    int m_owner [3];
    int m_ptr   [3];
    int m_held  [3];
    int m_idx   [3];
    int m_pulse [3];
    int to_cfg  [3];

    rr_grant_arbiter_8 #(.TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .gnt(gnt_o[0]),
        .gnt_idx(idx_o[0]), .gnt_valid(val_o[0]), .timeout_pulse(tp_o[0])
    );
    rr_grant_arbiter_8 #(.TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .gnt(gnt_o[1]),
        .gnt_idx(idx_o[1]), .gnt_valid(val_o[1]), .timeout_pulse(tp_o[1])
    );
    rr_grant_arbiter_8 dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_v[2]), .gnt(gnt_o[2]),
        .gnt_idx(idx_o[2]), .gnt_valid(val_o[2]), .timeout_pulse(tp_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_held[k]  = 0;
            m_idx[k]   = 0;
            m_pulse[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] r;
        int c;
        r = req_v[k];
        m_pulse[k] = 0;
        if (m_owner[k] < 0) begin
            for (int off = 0; off < 8; off++) begin
                c = (m_ptr[k] + off) % 8;
                if (m_owner[k] < 0 && r[c]) begin
                    m_owner[k] = c;
                    m_idx[k]   = c;
                    m_held[k]  = 1;
                end
            end
        end else if (!r[m_owner[k]]) begin
            m_ptr[k]   = (m_owner[k] + 1) % 8;
            m_owner[k] = -1;
        end else if (to_cfg[k] != 0 && m_held[k] == to_cfg[k]) begin
            m_ptr[k]   = (m_owner[k] + 1) % 8;
            m_owner[k] = -1;
            m_pulse[k] = 1;
        end else begin
            m_held[k]++;
        end
    endtask

    task automatic check_all(input string ph);
        logic [7:0] exp_g;
        for (int k = 0; k < 3; k++) begin
            exp_g = 8'h00;
            if (m_owner[k] >= 0) exp_g[m_owner[k]] = 1'b1;
            chk($sformatf("%s.u%0d.gnt", ph, k), gnt_o[k], exp_g);
            chk($sformatf("%s.u%0d.idx", ph, k), 8'(idx_o[k]), 8'(m_idx[k]));
            chk($sformatf("%s.u%0d.valid", ph, k), 8'(val_o[k]), 8'(m_owner[k] >= 0));
            chk($sformatf("%s.u%0d.tpulse", ph, k), 8'(tp_o[k]), 8'(m_pulse[k]));
            chk($sformatf("%s.u%0d.onehot0", ph, k), 8'($onehot0(gnt_o[k])), 8'd1);
            chk($sformatf("%s.u%0d.nox", ph, k),
                8'($isunknown({gnt_o[k], idx_o[k], val_o[k], tp_o[k]})), 8'd0);
            if (val_o[k] === 1'b1)
                chk($sformatf("%s.u%0d.decode", ph, k), gnt_o[k], 8'd1 << idx_o[k]);
        end
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        check_all(ph);
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        failures++;
        $display("FAIL %s observed=cycle_budget_expired expected=event", tag);
    endtask

    initial begin
        int n;
        to_cfg[0] = 4;
        to_cfg[1] = 0;
        to_cfg[2] = 16;
        for (int k = 0; k < 3; k++) req_v[k] = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #10;
        check_all("reset");
        rst_n = 1'b1;

        // Async reset while u0 holds 0x10.
        req_v[0] = 8'h10;
        cycle("pre_async");
        chk("async.gnt_before", gnt_o[0], 8'h10);
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_reset");
        req_v[0] = 8'h01;
        #1 rst_n = 1'b1;
        cycle("after_async");
        chk("async.gnt_restart", gnt_o[0], 8'h01);
        req_v[0] = 8'h00;
        cycle("drop0");
        cycle("idle0");

        // Single requester 5, then all requesting: pointer sits past 5.
        req_v[0] = 8'h20;
        cycle("single_grant");
        chk("single.gnt", gnt_o[0], 8'h20);
        chk("single.idx", 8'(idx_o[0]), 8'd5);
        cycle("single_hold");
        req_v[0] = 8'h00;
        cycle("single_drop");
        chk("single.released", gnt_o[0], 8'h00);
        req_v[0] = 8'hFF;
        cycle("all_req");
        chk("after5.idx", 8'(idx_o[0]), 8'd6);

        // Fairness with constant full request.
        for (int i = 0; i < 45; i++) cycle("fair");

        // Wrap-around: after owner 6 releases, 0 beats 6, then 6 follows.
        n = 0;
        while (m_owner[0] != 6 && n < 100) begin cycle("wait6"); n++; end
        if (n >= 100) bound_fail("wait_owner6");
        n = 0;
        while (m_owner[0] == 6 && n < 100) begin cycle("hold6"); n++; end
        if (n >= 100) bound_fail("wait_release6");
        req_v[0] = 8'h41;
        cycle("wrap_grant0");
        chk("wrap.gnt0", gnt_o[0], 8'h01);
        n = 0;
        while (m_owner[0] == 0 && n < 100) begin cycle("hold0"); n++; end
        if (n >= 100) bound_fail("wait_release0");
        chk("wrap.gap_pulse", 8'(tp_o[0]), 8'd1);
        cycle("wrap_grant6");
        chk("wrap.gnt6", gnt_o[0], 8'h40);

        // TIMEOUT=0: owner 3 keeps the grant while other bits churn.
        req_v[1] = 8'h08;
        cycle("noto_grant");
        for (int i = 0; i < 100; i++) begin
            req_v[1] = 8'h08 | (8'($urandom) & 8'hF7);
            req_v[0] = 8'($urandom);
            if ($urandom_range(3) == 0) req_v[2] = 8'($urandom);
            cycle("noto_hold");
            chk("noto.gnt", gnt_o[1], 8'h08);
            chk("noto.tpulse", 8'(tp_o[1]), 8'd0);
        end
        req_v[1] = 8'h00;
        req_v[0] = 8'h00;
        cycle("quiet1");
        cycle("quiet2");

        // Owner drops request in its last permitted cycle: normal release.
        req_v[0] = 8'h04;
        cycle("sim_grant");
        chk("sim.idx", 8'(idx_o[0]), 8'd2);
        cycle("sim_h2");
        cycle("sim_h3");
        cycle("sim_h4");
        req_v[0] = 8'h00;
        cycle("sim_release");
        chk("sim.gnt_off", gnt_o[0], 8'h00);
        chk("sim.tpulse", 8'(tp_o[0]), 8'd0);
        req_v[0] = 8'h0C;
        cycle("sim_next");
        chk("sim.ptr_adv", 8'(idx_o[0]), 8'd3);

        // Randomized traffic on all instances with sparse request changes.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(5) == 0) begin
                    req_v[k] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
                end
            end
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter_8.md
Name: rr_grant_arbiter_8

Overview:
- Eight-requester round-robin arbiter for one shared single-owner resource.
- Internally registers a 3-bit winner index and drives the one-hot grant vector as the 3-to-8 decode of that index.
- Grant is held until the owner drops its request, or until a programmable hold timeout forces release.
- Sits in front of any shared port (e.g. a bus slave or a buffer write port) where up to 8 agents contend.

Parameters:
- TIMEOUT, 16: maximum consecutive cycles one owner may hold the grant. 0 disables the timeout (hold indefinitely).
- CNT_W, $clog2(TIMEOUT+1) (minimum 1): width of the hold counter. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; req[i]=1 means requester i wants the resource. Level-sensitive.
- gnt  output  8  registered one-hot grant, or all-zero. Always equals decode(gnt_idx) when gnt_valid=1.
- gnt_idx  output  3  registered index of the current owner. Holds its last value while gnt_valid=0.
- gnt_valid  output  1  registered; 1 while any grant is active.
- timeout_pulse  output  1  registered one-cycle pulse in the cycle after a forced release.

Behaviour:
- Reset (async, rst_n=0) clears immediately, without waiting for a clock edge:
  - state=IDLE, ptr=0, hold_cnt=0
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout_pulse=0
- Reset asserted mid-grant drops the grant in the same instant. After release, arbitration restarts from ptr=0.
- Internal state: two-state FSM {IDLE, GRANT}; 3-bit priority pointer ptr; CNT_W-bit hold_cnt.
- IDLE:
  - If req==0: stay in IDLE; outputs hold at zero.
  - Else: the winner is the first i with req[i]=1, searching ptr, ptr+1, …, ptr+7, modulo 8 (wraps 7→0).
  - Next edge: gnt_idx←winner, gnt←decode(winner), gnt_valid←1, hold_cnt←0, state←GRANT.
  - Latency is 1 cycle from the req sampled in IDLE to gnt visible.
- GRANT: release condition = (req[gnt_idx]==0) OR (TIMEOUT!=0 AND hold_cnt==TIMEOUT-1).
  - On release, next edge: gnt←0, gnt_valid←0, ptr←gnt_idx+1 mod 8, hold_cnt←0, state←IDLE.
  - timeout_pulse←1 on that edge only if release was forced (req[gnt_idx] still 1).
  - Otherwise hold_cnt increments (saturating at TIMEOUT-1) and gnt is unchanged.
- Turnaround: exactly one idle cycle (gnt=0) between consecutive grants, even with requests pending. No bubble-free handoff.
- Grant hold: the owner keeps gnt for exactly the cycles it holds req, capped at TIMEOUT cycles.
  - With TIMEOUT=N and req held, gnt is high for exactly N cycles.
- Changes to other req bits during GRANT have no effect until the next IDLE cycle. No preemption except by timeout.
- A force-released requester still asserting req competes normally; it is now lowest priority (ptr moved past it).
- Simultaneous release by the owner and timeout expiry in the same cycle is treated as a normal release: timeout_pulse=0.
- timeout_pulse is 0 in every cycle other than the one following a forced release.
- Invariants (bench assertions):
  - $onehot0(gnt) always.
  - gnt_valid == |gnt.
  - gnt == (8'b1 << gnt_idx) whenever gnt_valid.
  - No X on any output after reset deassertion.

Test Plan:
- Async reset: with gnt=8'h10 held, drop rst_n between clock edges → gnt=0, gnt_valid=0 immediately. After release with req=8'h01 → gnt=8'h01 one cycle after the first sampling edge.
- Single requester: req=8'h20 sampled at edge N → gnt=8'h20, gnt_idx=5 at N+1. Drop req, sampled at edge M → gnt=0 at M+1; subsequent req=8'hFF → gnt_idx=6.
- Fairness, TIMEOUT=4, req=8'hFF constant → grants go 0,1,2,…,7,0. Each grant is high 4 cycles followed by a 1-cycle gap, with timeout_pulse=1 in every gap cycle.
- Wrap-around: after owner 6 releases (ptr=7), req=8'h41 → next gnt=8'h01 (index 0 beats 6). Then after 0 releases → gnt=8'h40.
- Timeout disabled, TIMEOUT=0: req=8'h08 held 100 cycles with other bits toggling → gnt stays 8'h08 for all 100 cycles; timeout_pulse never asserts.
- Simultaneous events, TIMEOUT=4: owner drops req in the same cycle hold_cnt==3 → normal release, timeout_pulse stays 0, ptr advances by one.
